// File: rtl/abs_window_sequencer.sv
// Windowed |x| integrator for one signed ADC stream: per window of N accepted
// samples it reports sum and peak of |x| and pulses done_o.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start with a non-zero length
// S_RUN   | accepting samples, down-counting remaining samples in window
// S_FLUSH | two cycles letting the |x| pipeline drain into the accumulator
// S_DONE  | publish sum/peak, pulse done_o, then re-arm (cont) or idle
module abs_window_sequencer #(
   parameter int  DATA_WIDTH = 16,
   parameter int  CNT_WIDTH  = 24,
   localparam int ACC_WIDTH  = DATA_WIDTH + CNT_WIDTH
) (
   input  logic                         clk_i,
   input  logic                         rstn_i,
   input  logic signed [DATA_WIDTH-1:0] adc_data_i,
   input  logic                         adc_valid_i,
   input  logic [CNT_WIDTH-1:0]         cfg_len_i,
   input  logic                         cfg_cont_i,
   input  logic                         start_i,
   input  logic                         abort_i,
   output logic                         busy_o,
   output logic                         done_o,
   output logic [ACC_WIDTH-1:0]         sum_o,
   output logic [DATA_WIDTH-1:0]        peak_o,
   output logic [15:0]                  win_cnt_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t                 state_q;
   logic [CNT_WIDTH-1:0]   len_q;
   logic                   cont_q;
   logic [CNT_WIDTH-1:0]   cnt_q;
   logic                   flush_cnt_q;

   logic [DATA_WIDTH-1:0]  smp_q;
   logic                   smp_vld_q;
   logic [DATA_WIDTH-1:0]  s1_mag_q;
   logic                   s1_vld_q;
   logic [ACC_WIDTH-1:0]   acc_q;
   logic [DATA_WIDTH-1:0]  peak_q;

   logic                   accept;
   logic [DATA_WIDTH-1:0]  smp_neg;
   logic [DATA_WIDTH-1:0]  smp_mag;

   assign accept  = (state_q == S_RUN) && adc_valid_i && !abort_i;

   // Two's-complement negate without saturation: the most negative code maps
   // onto 2^(DATA_WIDTH-1), which still fits the unsigned magnitude.
   assign smp_neg = ~smp_q + DATA_WIDTH'(1);
   assign smp_mag = smp_q[DATA_WIDTH-1] ? smp_neg : smp_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         cont_q      <= 1'b0;
         cnt_q       <= '0;
         flush_cnt_q <= 1'b0;
         smp_q       <= '0;
         smp_vld_q   <= 1'b0;
         s1_mag_q    <= '0;
         s1_vld_q    <= 1'b0;
         acc_q       <= '0;
         peak_q      <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         sum_o       <= '0;
         peak_o      <= '0;
         win_cnt_o   <= '0;
      end else begin
         done_o <= 1'b0;

         smp_vld_q <= accept;
         if (accept) begin
            smp_q <= adc_data_i;
         end
         s1_vld_q <= smp_vld_q;
         s1_mag_q <= smp_mag;
         if (s1_vld_q) begin
            acc_q <= acc_q + ACC_WIDTH'(s1_mag_q);
            if (s1_mag_q > peak_q) begin
               peak_q <= s1_mag_q;
            end
         end

         if (state_q != S_IDLE && abort_i) begin
            // Anything still in the pipeline belongs to the abandoned window.
            state_q   <= S_IDLE;
            busy_o    <= 1'b0;
            smp_vld_q <= 1'b0;
            s1_vld_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start_i && !abort_i && cfg_len_i != '0) begin
                     len_q     <= cfg_len_i;
                     cont_q    <= cfg_cont_i;
                     cnt_q     <= cfg_len_i;
                     acc_q     <= '0;
                     peak_q    <= '0;
                     win_cnt_o <= '0;
                     smp_vld_q <= 1'b0;
                     s1_vld_q  <= 1'b0;
                     busy_o    <= 1'b1;
                     state_q   <= S_RUN;
                  end
               end
               S_RUN: begin
                  if (accept) begin
                     if (cnt_q == CNT_WIDTH'(1)) begin
                        flush_cnt_q <= 1'b1;
                        state_q     <= S_FLUSH;
                     end else begin
                        cnt_q <= cnt_q - CNT_WIDTH'(1);
                     end
                  end
               end
               S_FLUSH: begin
                  if (flush_cnt_q == 1'b0) begin
                     state_q <= S_DONE;
                  end else begin
                     flush_cnt_q <= flush_cnt_q - 1'b1;
                  end
               end
               S_DONE: begin
                  sum_o     <= acc_q;
                  peak_o    <= peak_q;
                  win_cnt_o <= win_cnt_o + 16'd1;
                  done_o    <= 1'b1;
                  if (cont_q) begin
                     acc_q   <= '0;
                     peak_q  <= '0;
                     cnt_q   <= len_q;
                     state_q <= S_RUN;
                  end else begin
                     busy_o  <= 1'b0;
                     state_q <= S_IDLE;
                  end
               end
               default: begin
                  busy_o  <= 1'b0;
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_abs_window_sequencer.sv
// Directed bench for abs_window_sequencer: each scenario plays a cycle vector
// and checks done timing, results and busy against hand-computed values.
module tb_abs_window_sequencer;

   localparam int DW = 16;
   localparam int CW = 24;
   localparam int AW = DW + CW;
   localparam int VMAX = 40;

   logic                 clk_i = 1'b0;
   logic                 rstn_i;
   logic signed [DW-1:0] adc_data_i;
   logic                 adc_valid_i;
   logic [CW-1:0]        cfg_len_i;
   logic                 cfg_cont_i;
   logic                 start_i;
   logic                 abort_i;
   logic                 busy_o;
   logic                 done_o;
   logic [AW-1:0]        sum_o;
   logic [DW-1:0]        peak_o;
   logic [15:0]          win_cnt_o;

   int tests_run    = 0;
   int tests_failed = 0;

   logic          vec_s [VMAX];
   logic          vec_a [VMAX];
   logic          vec_v [VMAX];
   logic [DW-1:0] vec_d [VMAX];
   logic          busy_log [VMAX+1];

   int            done_t [$];
   logic [AW-1:0] sum_q  [$];
   logic [DW-1:0] peak_q [$];
   logic [15:0]   win_q  [$];

   abs_window_sequencer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .adc_data_i  (adc_data_i),
      .adc_valid_i (adc_valid_i),
      .cfg_len_i   (cfg_len_i),
      .cfg_cont_i  (cfg_cont_i),
      .start_i     (start_i),
      .abort_i     (abort_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .sum_o       (sum_o),
      .peak_o      (peak_o),
      .win_cnt_o   (win_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic clr_vec();
      for (int k = 0; k < VMAX; k++) begin
         vec_s[k] = 1'b0;
         vec_a[k] = 1'b0;
         vec_v[k] = 1'b0;
         vec_d[k] = '0;
      end
   endtask

   task automatic set_v(input int k, input logic s, input logic a, input logic v, input int d);
      vec_s[k] = s;
      vec_a[k] = a;
      vec_v[k] = v;
      vec_d[k] = DW'(d);
   endtask

   // Entry k is driven in the cycle ending at tick k+1; observations are
   // logged 1 time unit after that tick.
   task automatic play(input int n);
      done_t.delete();
      sum_q.delete();
      peak_q.delete();
      win_q.delete();
      for (int k = 0; k < n; k++) begin
         start_i     = vec_s[k];
         abort_i     = vec_a[k];
         adc_valid_i = vec_v[k];
         adc_data_i  = vec_d[k];
         @(posedge clk_i);
         #1;
         busy_log[k+1] = busy_o;
         if (done_o === 1'b1) begin
            done_t.push_back(k + 1);
            sum_q.push_back(sum_o);
            peak_q.push_back(peak_o);
            win_q.push_back(win_cnt_o);
         end
      end
      start_i     = 1'b0;
      abort_i     = 1'b0;
      adc_valid_i = 1'b0;
      adc_data_i  = '0;
   endtask

   task automatic test_reset();
      rstn_i      = 1'b0;
      adc_data_i  = '0;
      adc_valid_i = 1'b0;
      cfg_len_i   = '0;
      cfg_cont_i  = 1'b0;
      start_i     = 1'b0;
      abort_i     = 1'b0;
      #12;
      tests_run++;
      if ({busy_o, done_o, sum_o, peak_o, win_cnt_o} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: busy=%b done=%b sum=%0d peak=%0d win=%0d, required all 0",
                  busy_o, done_o, sum_o, peak_o, win_cnt_o);
      end
      rstn_i = 1'b1;
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_single_shot();
      cfg_len_i  = 24'd4;
      cfg_cont_i = 1'b0;
      clr_vec();
      set_v(0, 1, 0, 0, 0);
      set_v(1, 0, 0, 1, 3);
      set_v(2, 0, 0, 1, -5);
      set_v(3, 1, 0, 1, 2);
      set_v(4, 0, 0, 1, -1);
      for (int k = 5; k < 9; k++) set_v(k, 0, 0, 1, 100);
      play(14);
      tests_run++;
      if (done_t.size() != 1) begin
         tests_failed++;
         $display("FAIL single_done_count: got %0d pulses, required 1", done_t.size());
      end else begin
         tests_run++;
         if (done_t[0] != 8) begin
            tests_failed++;
            $display("FAIL single_latency: done at tick %0d, required 8", done_t[0]);
         end
         tests_run++;
         if (sum_q[0] !== AW'(11)) begin
            tests_failed++;
            $display("FAIL single_sum: got %0d, required 11", sum_q[0]);
         end
         tests_run++;
         if (peak_q[0] !== 16'd5) begin
            tests_failed++;
            $display("FAIL single_peak: got %0d, required 5", peak_q[0]);
         end
         tests_run++;
         if (win_q[0] !== 16'd1) begin
            tests_failed++;
            $display("FAIL single_win_cnt: got %0d, required 1", win_q[0]);
         end
         tests_run++;
         if (busy_log[done_t[0]-1] !== 1'b1 || busy_log[done_t[0]+1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_busy: before done %b after done %b, required 1 then 0",
                     busy_log[done_t[0]-1], busy_log[done_t[0]+1]);
         end
      end
   endtask

   task automatic test_extremes();
      cfg_len_i  = 24'd2;
      cfg_cont_i = 1'b0;
      clr_vec();
      set_v(0, 1, 0, 0, 0);
      set_v(1, 0, 0, 1, 32'h8000);
      set_v(2, 0, 0, 1, 32'h7FFF);
      play(8);
      tests_run++;
      if (done_t.size() != 1) begin
         tests_failed++;
         $display("FAIL extreme_done_count: got %0d pulses, required 1", done_t.size());
      end else begin
         tests_run++;
         if (sum_q[0] !== AW'(65535) || peak_q[0] !== 16'd32768) begin
            tests_failed++;
            $display("FAIL extreme_values: sum %0d peak %0d, required 65535 and 32768",
                     sum_q[0], peak_q[0]);
         end
         tests_run++;
         if (done_t[0] != 6) begin
            tests_failed++;
            $display("FAIL extreme_latency: done at tick %0d, required 6", done_t[0]);
         end
      end
   endtask

   task automatic test_valid_gaps();
      cfg_len_i  = 24'd3;
      cfg_cont_i = 1'b0;
      clr_vec();
      set_v(0, 1, 0, 0, 0);
      set_v(1, 0, 0, 1, -2);
      set_v(2, 0, 0, 0, 99);
      set_v(3, 0, 0, 1, 4);
      set_v(4, 0, 0, 0, 77);
      set_v(5, 0, 0, 1, -6);
      set_v(6, 0, 0, 0, 100);
      set_v(7, 0, 0, 1, 50);
      set_v(8, 0, 0, 0, 0);
      set_v(9, 0, 0, 1, 60);
      play(14);
      tests_run++;
      if (done_t.size() != 1) begin
         tests_failed++;
         $display("FAIL gaps_done_count: got %0d pulses, required 1", done_t.size());
      end else begin
         tests_run++;
         if (sum_q[0] !== AW'(12) || peak_q[0] !== 16'd6) begin
            tests_failed++;
            $display("FAIL gaps_values: sum %0d peak %0d, required 12 and 6", sum_q[0], peak_q[0]);
         end
         tests_run++;
         if (done_t[0] != 9) begin
            tests_failed++;
            $display("FAIL gaps_latency: done at tick %0d, required 9", done_t[0]);
         end
      end
   endtask

   task automatic test_continuous();
      cfg_len_i  = 24'd2;
      cfg_cont_i = 1'b1;
      clr_vec();
      set_v(0, 1, 0, 0, 0);
      for (int k = 1; k <= 20; k++) set_v(k, 0, 0, 1, -10);
      set_v(21, 0, 1, 1, -10);
      for (int k = 22; k < 30; k++) set_v(k, 0, 0, 1, -10);
      cfg_cont_i = 1'b1;
      play(30);
      cfg_cont_i = 1'b0;
      tests_run++;
      if (done_t.size() != 4) begin
         tests_failed++;
         $display("FAIL cont_done_count: got %0d pulses, required 4", done_t.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (done_t[i] != 6 + 5 * i) begin
               tests_failed++;
               $display("FAIL cont_spacing[%0d]: done at tick %0d, required %0d", i, done_t[i], 6 + 5 * i);
            end
            tests_run++;
            if (sum_q[i] !== AW'(20) || peak_q[i] !== 16'd10 || win_q[i] !== 16'(i + 1)) begin
               tests_failed++;
               $display("FAIL cont_window[%0d]: sum %0d peak %0d win %0d, required 20 10 %0d",
                        i, sum_q[i], peak_q[i], win_q[i], i + 1);
            end
         end
      end
      tests_run++;
      if (busy_log[22] !== 1'b0 || busy_log[29] !== 1'b0) begin
         tests_failed++;
         $display("FAIL cont_abort_busy: busy %b/%b after abort, required 0/0", busy_log[22], busy_log[29]);
      end
      tests_run++;
      if (sum_o !== AW'(20) || peak_o !== 16'd10 || win_cnt_o !== 16'd4) begin
         tests_failed++;
         $display("FAIL cont_abort_hold: sum %0d peak %0d win %0d, required 20 10 4", sum_o, peak_o, win_cnt_o);
      end
   endtask

   task automatic test_ignored_starts();
      int busy_seen;
      cfg_len_i = '0;
      clr_vec();
      for (int k = 0; k < 3; k++) set_v(k, 1, 0, 1, 7);
      play(6);
      busy_seen = 0;
      for (int k = 1; k <= 6; k++) if (busy_log[k] !== 1'b0) busy_seen++;
      tests_run++;
      if (busy_seen != 0 || done_t.size() != 0) begin
         tests_failed++;
         $display("FAIL zero_len_start: busy cycles %0d done pulses %0d, required 0 and 0", busy_seen, done_t.size());
      end
      cfg_len_i = 24'd1;
      clr_vec();
      for (int k = 0; k < 3; k++) set_v(k, 1, 1, 1, 7);
      play(6);
      busy_seen = 0;
      for (int k = 1; k <= 6; k++) if (busy_log[k] !== 1'b0) busy_seen++;
      tests_run++;
      if (busy_seen != 0 || done_t.size() != 0 || win_cnt_o !== 16'd4) begin
         tests_failed++;
         $display("FAIL start_with_abort: busy cycles %0d done %0d win %0d, required 0 0 4",
                  busy_seen, done_t.size(), win_cnt_o);
      end
   endtask

   task automatic test_n_one();
      cfg_len_i = 24'd1;
      clr_vec();
      set_v(0, 1, 0, 0, 0);
      set_v(1, 0, 0, 1, -9);
      set_v(2, 0, 0, 1, 30);
      play(7);
      tests_run++;
      if (done_t.size() != 1) begin
         tests_failed++;
         $display("FAIL n1_done_count: got %0d pulses, required 1", done_t.size());
      end else begin
         tests_run++;
         if (done_t[0] != 5 || sum_q[0] !== AW'(9) || peak_q[0] !== 16'd9 || win_q[0] !== 16'd1) begin
            tests_failed++;
            $display("FAIL n1_window: tick %0d sum %0d peak %0d win %0d, required 5 9 9 1",
                     done_t[0], sum_q[0], peak_q[0], win_q[0]);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      int busy_seen;
      cfg_len_i = 24'd10;
      clr_vec();
      set_v(0, 1, 0, 0, 0);
      for (int k = 1; k <= 5; k++) set_v(k, 0, 0, 1, 3);
      play(6);
      tests_run++;
      if (busy_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL midrun_busy_before: got %b, required 1", busy_o);
      end
      #3;
      rstn_i = 1'b0;
      #1;
      tests_run++;
      if ({busy_o, done_o, sum_o, peak_o, win_cnt_o} !== '0) begin
         tests_failed++;
         $display("FAIL midrun_reset_outputs: busy=%b done=%b sum=%0d peak=%0d win=%0d, required all 0",
                  busy_o, done_o, sum_o, peak_o, win_cnt_o);
      end
      @(posedge clk_i);
      #2;
      rstn_i = 1'b1;
      clr_vec();
      for (int k = 0; k < 10; k++) set_v(k, 0, 0, 1, 3);
      play(10);
      busy_seen = 0;
      for (int k = 1; k <= 10; k++) if (busy_log[k] !== 1'b0) busy_seen++;
      tests_run++;
      if (busy_seen != 0 || done_t.size() != 0) begin
         tests_failed++;
         $display("FAIL midrun_after_reset: busy cycles %0d done pulses %0d, required 0 and 0",
                  busy_seen, done_t.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_shot();
      test_extremes();
      test_valid_gaps();
      test_n_one();
      test_continuous();
      test_ignored_starts();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/abs_window_sequencer.md
Name: abs_window_sequencer

Overview:
- Sequences absolute-value integration of one signed ADC stream over programmable windows of N accepted samples.
- Per window, reports the sum and peak of |x| and emits a done strobe. Supports single-shot and back-to-back continuous windows.
- Sits between the ADC sample path and the register/readout layer, and feeds the downstream Boltzmann statistics logic.

Parameters:
- DATA_WIDTH, 16, ADC sample width (two's complement).
- CNT_WIDTH, 24, window-length/counter width.
- ACC_WIDTH (localparam) = DATA_WIDTH+CNT_WIDTH, accumulator width; cannot overflow by construction.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- adc_data_i  in  DATA_WIDTH  signed sample.
- adc_valid_i  in  1  sample qualifier.
- cfg_len_i  in  CNT_WIDTH  window length N; sampled only on accepted start.
- cfg_cont_i  in  1  continuous mode; sampled only on accepted start.
- start_i  in  1  level-sampled start request.
- abort_i  in  1  abort current run.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when results update.
- sum_o  out  ACC_WIDTH  unsigned sum of |x| over last completed window.
- peak_o  out  DATA_WIDTH  unsigned max |x| over last completed window.
- win_cnt_o  out  16  completed windows since start; wraps 0xFFFF->0.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy_o, done_o = 0; sum_o, peak_o, win_cnt_o, accumulators and counters = 0.
- |x| rule: magnitude is computed as an unsigned DATA_WIDTH value. The most negative input maps to 2^(DATA_WIDTH-1); for example, 0x8000 gives 32768. No saturation.
- Datapath pipeline:
  - Stage 1 registers |x| and its valid flag.
  - Stage 2 adds it into acc and updates the running peak.
  - A sample accepted at edge t is included in acc at edge t+2.
- States:
  - IDLE:
    - If start_i=1, abort_i=0 and cfg_len_i!=0: latch N and cont, clear acc/peak/sample count and win_cnt_o, go to RUN.
    - start_i with cfg_len_i=0 is ignored; the block stays in IDLE.
  - RUN:
    - A sample is accepted when adc_valid_i=1.
    - On the N-th accepted sample, go to FLUSH.
    - Further samples are not accepted until the next RUN.
  - FLUSH: waits 2 cycles for the pipeline to drain, then goes to DONE.
  - DONE (1 cycle):
    - Load sum_o<=acc and peak_o<=peak, increment win_cnt_o.
    - done_o=1 for this cycle only; the outputs are visible together with done_o.
    - Next state is RUN with acc/peak/count cleared if cont=1, else IDLE.
- Continuous mode dead time: samples presented in FLUSH/DONE are dropped, a 3-cycle gap per window. Downstream accepts this gap.
- Priority:
  - abort_i=1 in any non-IDLE state forces IDLE on the next edge. No done_o is produced; sum_o, peak_o and win_cnt_o hold their last values.
  - abort_i beats start_i in the same cycle.
- start_i while busy: ignored. cfg_* changes while busy: no effect.
- Latency, single-shot: done_o rises 3 cycles after the edge that accepts the N-th sample (2 FLUSH cycles + DONE). busy_o falls on the edge after DONE.
- N=1 is legal and follows the identical sequence.

Test Plan:
- Reset mid-RUN (rstn_i low for 1 cycle after 5 samples) -> all outputs 0 immediately, state IDLE, no done_o.
- N=4, single-shot, valid continuous, samples +3,-5,+2,-1 -> one done_o; sum_o=11, peak_o=5, win_cnt_o=1; busy_o low one cycle after done_o.
- N=2, samples 0x8000,0x7FFF -> sum_o=65535, peak_o=32768.
- N=3, adc_valid_i toggling every other cycle with samples -2,4,-6 -> sum_o=12, peak_o=6; gaps add no extra samples.
- Continuous, N=2, constant input -10 for 20 cycles, then abort_i:
  - each window gives sum_o=20, peak_o=10;
  - done_o spacing is 5 cycles (2 RUN + 3 dead time);
  - win_cnt_o increments per window;
  - after abort, busy_o=0 and no further done_o.
- start_i with cfg_len_i=0 -> stays IDLE, busy_o=0. Simultaneous start_i and abort_i in IDLE -> no start. start_i pulsed during RUN -> window unaffected.
